// File: rtl/mem_access_pkg.sv
// Shared definitions for the MEM stage: ALU opcodes, FSM state encodings, reset/write constants.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package mem_access_pkg;

   localparam int ALUOP_W = 8;

   // Load/store opcodes on AluOpBus; every other value is a non-memory op.
   localparam logic [ALUOP_W-1:0] EXE_NONE = 8'h00;
   localparam logic [ALUOP_W-1:0] EXE_LB   = 8'hE0;
   localparam logic [ALUOP_W-1:0] EXE_LH   = 8'hE1;
   localparam logic [ALUOP_W-1:0] EXE_LW   = 8'hE3;
   localparam logic [ALUOP_W-1:0] EXE_LBU  = 8'hE4;
   localparam logic [ALUOP_W-1:0] EXE_LHU  = 8'hE5;
   localparam logic [ALUOP_W-1:0] EXE_SB   = 8'hE8;
   localparam logic [ALUOP_W-1:0] EXE_SH   = 8'hE9;
   localparam logic [ALUOP_W-1:0] EXE_SW   = 8'hEB;

   localparam logic [1:0] MEM_IDLE = 2'd0;
   localparam logic [1:0] MEM_BUSY = 2'd1;
   localparam logic [1:0] MEM_DONE = 2'd2;

   localparam logic        RST_ENABLE    = 1'b1;
   localparam logic [31:0] ZERO_WORD     = 32'h0000_0000;
   localparam logic        WRITE_DISABLE = 1'b0;

   function automatic logic is_load(input logic [ALUOP_W-1:0] op);
      return (op == EXE_LB) || (op == EXE_LH) || (op == EXE_LW) ||
             (op == EXE_LBU) || (op == EXE_LHU);
   endfunction

   function automatic logic is_store(input logic [ALUOP_W-1:0] op);
      return (op == EXE_SB) || (op == EXE_SH) || (op == EXE_SW);
   endfunction

endpackage

// File: rtl/mem_access_align.sv
// Byte-lane steering for the MEM stage: byte enables, store lane data, load extension, misalignment.
// Latency: purely combinational, zero cycles.
// Backpressure: none; stateless.
// Ports: aluop_i/addr_lo_i/reg2_i/rdata_i in; be_o, wdata_o, ld_data_o, misalign_o out.
module mem_align
   import mem_access_pkg::*;
(
   input  logic [ALUOP_W-1:0] aluop_i,
   input  logic [1:0]         addr_lo_i,
   input  logic [31:0]        reg2_i,
   input  logic [31:0]        rdata_i,
   output logic [3:0]         be_o,
   output logic [31:0]        wdata_o,
   output logic [31:0]        ld_data_o,
   output logic               misalign_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   assign byte_sel = rdata_i[{addr_lo_i, 3'b000} +: 8];
   assign half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

   always_comb begin
      be_o       = 4'b0000;
      wdata_o    = reg2_i;
      ld_data_o  = rdata_i;
      misalign_o = 1'b0;
      case (aluop_i)
         EXE_LB:  begin be_o = 4'hF; ld_data_o = {{24{byte_sel[7]}}, byte_sel}; end
         EXE_LBU: begin be_o = 4'hF; ld_data_o = {24'h0, byte_sel}; end
         EXE_LH:  begin
            be_o = 4'hF; misalign_o = addr_lo_i[0];
            ld_data_o = {{16{half_sel[15]}}, half_sel};
         end
         EXE_LHU: begin
            be_o = 4'hF; misalign_o = addr_lo_i[0];
            ld_data_o = {16'h0, half_sel};
         end
         EXE_LW:  begin be_o = 4'hF; misalign_o = |addr_lo_i; end
         EXE_SB:  begin be_o = 4'b0001 << addr_lo_i; wdata_o = {4{reg2_i[7:0]}}; end
         EXE_SH:  begin
            misalign_o = addr_lo_i[0];
            be_o       = addr_lo_i[1] ? 4'b1100 : 4'b0011;
            wdata_o    = {2{reg2_i[15:0]}};
         end
         EXE_SW:  begin be_o = 4'hF; misalign_o = |addr_lo_i; end
         default: ;
      endcase
   end

endmodule

// File: rtl/mem_access.sv
// MEM pipeline stage: passes ALU results through and runs load/store req/ack transactions on the data bus.
// Latency: non-memory ops 0 cycles; memory ops >= 2 cycles (issue/busy cycles stall, result in DONE).
// Backpressure: stallreq_mem_o held while the request is outstanding; EX/MEM holds its inputs meanwhile.
// Ports: clk/rst; mem_* from EX/MEM; wb_* to MEM/WB; dbus_* data bus; stall, misalign and busfault flags.
module mem_access
   import mem_access_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [4:0]         mem_wd_i,
   input  logic               mem_wreg_i,
   input  logic [DATA_W-1:0]  mem_wdata_i,
   input  logic [ALUOP_W-1:0] mem_aluop_i,
   input  logic [ADDR_W-1:0]  mem_addr_i,
   input  logic [DATA_W-1:0]  mem_reg2_i,
   output logic [4:0]         wb_wd_o,
   output logic               wb_wreg_o,
   output logic [DATA_W-1:0]  wb_wdata_o,
   output logic               dbus_req_o,
   output logic               dbus_we_o,
   output logic [ADDR_W-1:0]  dbus_addr_o,
   output logic [3:0]         dbus_be_o,
   output logic [DATA_W-1:0]  dbus_wdata_o,
   input  logic [DATA_W-1:0]  dbus_rdata_i,
   input  logic               dbus_ack_i,
   input  logic               dbus_err_i,
   output logic               stallreq_mem_o,
   output logic               misalign_o,
   output logic               busfault_o
);

   logic [1:0]        state_q, state_d;
   logic [DATA_W-1:0] ld_data_q, ld_data_d;
   logic              err_q, err_d;

   logic [3:0]        lane_be;
   logic [DATA_W-1:0] lane_wdata;
   logic [DATA_W-1:0] lane_ld;
   logic              lane_misalign;
   logic              op_load, op_mem;

   mem_align u_align (
      .aluop_i    (mem_aluop_i),
      .addr_lo_i  (mem_addr_i[1:0]),
      .reg2_i     (mem_reg2_i),
      .rdata_i    (dbus_rdata_i),
      .be_o       (lane_be),
      .wdata_o    (lane_wdata),
      .ld_data_o  (lane_ld),
      .misalign_o (lane_misalign)
   );

   assign op_load = is_load(mem_aluop_i);
   assign op_mem  = op_load | is_store(mem_aluop_i);

   always_comb begin
      state_d        = state_q;
      ld_data_d      = ld_data_q;
      err_d          = err_q;
      dbus_req_o     = 1'b0;
      stallreq_mem_o = 1'b0;
      misalign_o     = 1'b0;
      busfault_o     = 1'b0;
      wb_wd_o        = mem_wd_i;
      wb_wreg_o      = mem_wreg_i;
      wb_wdata_o     = mem_wdata_i;
      case (state_q)
         MEM_IDLE, MEM_BUSY: begin
            if (op_mem && !lane_misalign) begin
               dbus_req_o     = 1'b1;
               stallreq_mem_o = 1'b1;
               // err wins over a simultaneous ack: load data is left untouched
               if (dbus_err_i) begin
                  err_d   = 1'b1;
                  state_d = MEM_DONE;
               end else if (dbus_ack_i) begin
                  ld_data_d = lane_ld;
                  state_d   = MEM_DONE;
               end else begin
                  state_d = MEM_BUSY;
               end
            end else begin
               state_d = MEM_IDLE;
               if (op_mem && state_q == MEM_IDLE) begin
                  misalign_o = 1'b1;
                  wb_wreg_o  = WRITE_DISABLE;
               end
            end
         end
         MEM_DONE: begin
            // bus is ignored here; err_q is consumed so the next op starts clean
            state_d = MEM_IDLE;
            err_d   = 1'b0;
            if (op_load) wb_wdata_o = ld_data_q;
            if (err_q) begin
               wb_wreg_o  = WRITE_DISABLE;
               busfault_o = 1'b1;
            end
         end
         default: state_d = MEM_IDLE;
      endcase
      // a reset abandons any outstanding request in the same cycle
      if (rst == RST_ENABLE) begin
         dbus_req_o     = 1'b0;
         stallreq_mem_o = 1'b0;
         misalign_o     = 1'b0;
         busfault_o     = 1'b0;
         wb_wreg_o      = mem_wreg_i;
         wb_wdata_o     = mem_wdata_i;
      end
   end

   assign dbus_we_o    = dbus_req_o & is_store(mem_aluop_i);
   assign dbus_be_o    = dbus_req_o ? lane_be : 4'b0000;
   assign dbus_addr_o  = {mem_addr_i[ADDR_W-1:2], 2'b00};
   assign dbus_wdata_o = lane_wdata;

   always_ff @(posedge clk) begin
      if (rst == RST_ENABLE) begin
         state_q   <= MEM_IDLE;
         ld_data_q <= ZERO_WORD;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         ld_data_q <= ld_data_d;
         err_q     <= err_d;
      end
   end

endmodule

// File: tb/tb_mem_access.sv
module tb_mem_access;
   import mem_access_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  mem_wd_i;
   logic        mem_wreg_i;
   logic [31:0] mem_wdata_i;
   logic [7:0]  mem_aluop_i;
   logic [31:0] mem_addr_i;
   logic [31:0] mem_reg2_i;
   logic [4:0]  wb_wd_o;
   logic        wb_wreg_o;
   logic [31:0] wb_wdata_o;
   logic        dbus_req_o, dbus_we_o;
   logic [31:0] dbus_addr_o;
   logic [3:0]  dbus_be_o;
   logic [31:0] dbus_wdata_o;
   logic [31:0] dbus_rdata_i;
   logic        dbus_ack_i, dbus_err_i;
   logic        stallreq_mem_o, misalign_o, busfault_o;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   mem_access #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .rst(rst),
      .mem_wd_i(mem_wd_i), .mem_wreg_i(mem_wreg_i), .mem_wdata_i(mem_wdata_i),
      .mem_aluop_i(mem_aluop_i), .mem_addr_i(mem_addr_i), .mem_reg2_i(mem_reg2_i),
      .wb_wd_o(wb_wd_o), .wb_wreg_o(wb_wreg_o), .wb_wdata_o(wb_wdata_o),
      .dbus_req_o(dbus_req_o), .dbus_we_o(dbus_we_o), .dbus_addr_o(dbus_addr_o),
      .dbus_be_o(dbus_be_o), .dbus_wdata_o(dbus_wdata_o), .dbus_rdata_i(dbus_rdata_i),
      .dbus_ack_i(dbus_ack_i), .dbus_err_i(dbus_err_i),
      .stallreq_mem_o(stallreq_mem_o), .misalign_o(misalign_o), .busfault_o(busfault_o)
   );

   // ---------------- reference model ----------------
   function automatic int op_size(input logic [7:0] op);
      if (op == EXE_LB || op == EXE_LBU || op == EXE_SB) return 1;
      if (op == EXE_LH || op == EXE_LHU || op == EXE_SH) return 2;
      if (op == EXE_LW || op == EXE_SW) return 4;
      return 0;
   endfunction

   function automatic bit m_load(input logic [7:0] op);
      return (op == EXE_LB || op == EXE_LBU || op == EXE_LH || op == EXE_LHU || op == EXE_LW);
   endfunction

   function automatic bit m_store(input logic [7:0] op);
      return op_size(op) != 0 && !m_load(op);
   endfunction

   function automatic bit m_misaligned(input logic [7:0] op, input logic [31:0] a);
      int sz = op_size(op);
      return sz != 0 && (a % sz) != 0;
   endfunction

   function automatic logic [3:0] m_be(input logic [7:0] op, input logic [31:0] a);
      int v;
      if (m_load(op)) return 4'hF;
      v = ((1 << op_size(op)) - 1) << (a % 4);
      return v[3:0];
   endfunction

   function automatic logic [31:0] m_wdata(input logic [7:0] op, input logic [31:0] r2);
      if (op == EXE_SB) return {24'h0, r2[7:0]} * 32'h0101_0101;
      if (op == EXE_SH) return {16'h0, r2[15:0]} * 32'h0001_0001;
      return r2;
   endfunction

   function automatic logic [31:0] m_ld(input logic [7:0] op, input logic [31:0] a, input logic [31:0] rd);
      longint v;
      longint span;
      int sz = op_size(op);
      span = longint'(1) << (8 * sz);
      v = (longint'({32'h0, rd}) >> (8 * (a % 4))) % span;
      if ((op == EXE_LB || op == EXE_LH) && v >= span / 2) v = v - span;
      return v[31:0];
   endfunction

   // ---------------- scenario tasks ----------------
   task automatic idle_inputs();
      mem_aluop_i = EXE_NONE; mem_wd_i = '0; mem_wreg_i = 1'b0; mem_wdata_i = '0;
      mem_addr_i = '0; mem_reg2_i = '0; dbus_ack_i = 1'b0; dbus_err_i = 1'b0; dbus_rdata_i = '0;
   endtask

   task automatic run_nonmem(input string nm, input logic [7:0] op, input logic [31:0] res,
                             input logic [4:0] rd, input logic wr);
      @(negedge clk);
      mem_aluop_i = op; mem_wdata_i = res; mem_wd_i = rd; mem_wreg_i = wr;
      mem_addr_i = $urandom; mem_reg2_i = $urandom; dbus_ack_i = 1'b0; dbus_err_i = 1'b0;
      #2;
      checks++;
      if (wb_wdata_o !== res || wb_wreg_o !== wr || wb_wd_o !== rd ||
          dbus_req_o !== 1'b0 || stallreq_mem_o !== 1'b0 || misalign_o !== 1'b0) begin
         errors++;
         $display("FAIL %s passthru: wdata=%h wreg=%b wd=%0d req=%b stall=%b mis=%b want %h %b %0d 0 0 0",
                  nm, wb_wdata_o, wb_wreg_o, wb_wd_o, dbus_req_o, stallreq_mem_o, misalign_o, res, wr, rd);
      end
      @(posedge clk);
   endtask

   task automatic run_misalign(input string nm, input logic [7:0] op, input logic [31:0] a);
      @(negedge clk);
      mem_aluop_i = op; mem_addr_i = a; mem_wreg_i = 1'b1; mem_wd_i = 5'd7; mem_reg2_i = $urandom;
      dbus_ack_i = 1'b0; dbus_err_i = 1'b0;
      #2;
      checks++;
      if (misalign_o !== 1'b1 || wb_wreg_o !== 1'b0 || dbus_req_o !== 1'b0 || stallreq_mem_o !== 1'b0) begin
         errors++;
         $display("FAIL %s misalign: mis=%b wreg=%b req=%b stall=%b want 1 0 0 0",
                  nm, misalign_o, wb_wreg_o, dbus_req_o, stallreq_mem_o);
      end
      @(posedge clk);
   endtask

   // Bus responds (ack, plus err when e) dly cycles after the op is presented.
   task automatic run_mem(input string nm, input logic [7:0] op, input logic [31:0] a,
                          input logic [31:0] r2, input logic [31:0] rd, input int dly, input bit e);
      int stalls = 0;
      logic [4:0]  wd_v = 5'($urandom);
      logic        wr_v = m_load(op) ? 1'b1 : 1'($urandom);
      logic [31:0] alu_v = $urandom;
      @(negedge clk);
      mem_aluop_i = op; mem_addr_i = a; mem_reg2_i = r2;
      mem_wd_i = wd_v; mem_wreg_i = wr_v; mem_wdata_i = alu_v;
      for (int c = 0; c <= dly; c++) begin
         if (c > 0) @(negedge clk);
         dbus_ack_i   = (c == dly);
         dbus_err_i   = e && (c == dly);
         dbus_rdata_i = (c == dly) ? rd : $urandom;
         #2;
         if (stallreq_mem_o === 1'b1) stalls++;
         checks++;
         if (dbus_req_o !== 1'b1 || dbus_we_o !== m_store(op) || dbus_be_o !== m_be(op, a) ||
             dbus_addr_o !== (a & 32'hFFFF_FFFC) || misalign_o !== 1'b0 ||
             (m_store(op) && dbus_wdata_o !== m_wdata(op, r2))) begin
            errors++;
            $display("FAIL %s bus c%0d: req=%b we=%b be=%b addr=%h wdata=%h want 1 %b %b %h %h",
                     nm, c, dbus_req_o, dbus_we_o, dbus_be_o, dbus_addr_o, dbus_wdata_o,
                     m_store(op), m_be(op, a), a & 32'hFFFF_FFFC, m_wdata(op, r2));
         end
         @(posedge clk);
      end
      @(negedge clk);
      dbus_ack_i = 1'b0; dbus_err_i = 1'b0; dbus_rdata_i = $urandom;
      #2;
      checks++;
      if (stalls != dly + 1) begin
         errors++;
         $display("FAIL %s stall_cycles: got %0d want %0d", nm, stalls, dly + 1);
      end
      checks++;
      if (dbus_req_o !== 1'b0 || stallreq_mem_o !== 1'b0 || busfault_o !== e ||
          wb_wreg_o !== (e ? 1'b0 : wr_v) || wb_wd_o !== wd_v ||
          (!e && wb_wdata_o !== (m_load(op) ? m_ld(op, a, rd) : alu_v))) begin
         errors++;
         $display("FAIL %s done: req=%b stall=%b bf=%b wreg=%b wd=%0d wdata=%h want 0 0 %b %b %0d %h",
                  nm, dbus_req_o, stallreq_mem_o, busfault_o, wb_wreg_o, wb_wd_o, wb_wdata_o,
                  e, e ? 1'b0 : wr_v, wd_v, m_load(op) ? m_ld(op, a, rd) : alu_v);
      end
      @(posedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle_inputs();
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if (dbus_req_o !== 1'b0 || dbus_we_o !== 1'b0 || stallreq_mem_o !== 1'b0 ||
          misalign_o !== 1'b0 || busfault_o !== 1'b0 || dbus_be_o !== 4'b0000) begin
         errors++;
         $display("FAIL reset_outputs: req=%b we=%b stall=%b mis=%b bf=%b be=%b want all 0",
                  dbus_req_o, dbus_we_o, stallreq_mem_o, misalign_o, busfault_o, dbus_be_o);
      end
      rst = 1'b0;
      @(posedge clk);
   endtask

   task automatic test_reset_mid_busy();
      @(negedge clk);
      mem_aluop_i = EXE_LW; mem_addr_i = 32'h0000_4000; mem_wreg_i = 1'b1;
      dbus_ack_i = 1'b0; dbus_err_i = 1'b0;
      @(posedge clk);
      @(negedge clk);
      #2;
      checks++;
      if (dbus_req_o !== 1'b1 || stallreq_mem_o !== 1'b1) begin
         errors++;
         $display("FAIL busy_before_reset: req=%b stall=%b want 1 1", dbus_req_o, stallreq_mem_o);
      end
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         rst = 1'b1;
         #2;
         checks++;
         if (dbus_req_o !== 1'b0 || stallreq_mem_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_busy c%0d: req=%b stall=%b want 0 0", k, dbus_req_o, stallreq_mem_o);
         end
         @(posedge clk);
      end
      @(negedge clk);
      rst = 1'b0;
      idle_inputs();
      @(posedge clk);
      // back in IDLE: an immediately acked word load takes exactly one stall cycle
      run_mem("after_reset_lw", EXE_LW, 32'h0000_4004, 32'h0, 32'hCAFE_F00D, 0, 1'b0);
   endtask

   task automatic test_directed();
      run_nonmem("add", 8'h20, 32'h0000_1234, 5'd5, 1'b1);
      run_mem("lb_sext", EXE_LB, 32'h0000_1003, 32'h0, 32'h8012_3456, 3, 1'b0);
      run_mem("lbu_zext", EXE_LBU, 32'h0000_1003, 32'h0, 32'h8012_3456, 3, 1'b0);
      run_mem("sh_hi", EXE_SH, 32'h0000_2002, 32'hDEAD_BEEF, 32'h0, 0, 1'b0);
      run_misalign("lw_misalign", EXE_LW, 32'h0000_3001);
      run_nonmem("after_misalign", EXE_NONE, 32'h0000_0042, 5'd3, 1'b1);
      run_mem("lw_err_ack", EXE_LW, 32'h0000_3000, 32'h0, 32'h1111_2222, 0, 1'b1);
      run_mem("lh_after_err", EXE_LH, 32'h0000_3002, 32'h0, 32'h9ABC_0000, 1, 1'b0);
      run_mem("sb_lane1", EXE_SB, 32'h0000_5001, 32'h0000_00A5, 32'h0, 2, 1'b0);
      run_mem("sw", EXE_SW, 32'h0000_6000, 32'h0102_0304, 32'h0, 1, 1'b0);
   endtask

   task automatic test_random();
      logic [7:0] ops [11];
      logic [7:0] op;
      logic [31:0] a;
      ops = '{EXE_LB, EXE_LH, EXE_LW, EXE_LBU, EXE_LHU, EXE_SB, EXE_SH, EXE_SW, EXE_NONE, 8'h20, 8'h25};
      for (int i = 0; i < 60; i++) begin
         op = ops[$urandom_range(0, 10)];
         a  = $urandom;
         if (op_size(op) == 0)
            run_nonmem("rnd_alu", op, $urandom, 5'($urandom), 1'($urandom));
         else if (m_misaligned(op, a))
            run_misalign("rnd_mis", op, a);
         else
            run_mem("rnd_mem", op, a, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 7) == 0);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_reset_mid_busy();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
